mdu_ctrl: RTL and testbench

Controller for the multiply/divide unit (MDU) in the five-stage MIPS pipeline. It sits beside the Execute-stage ALU. It starts `mult`/`multu`/`div`/`divu`, models their multi-cycle latency with a busy counter, and owns the HI/LO registers. It serves `mthi`/`mtlo`/`mfhi`/`mflo`. It also raises the stall request the hazard unit uses to hold any MD-class instruction in Decode while the MDU is occupied.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_arith.sv | 35 +++
 rtl/mdu_ctrl.sv | 99 +++++++++
 tb/tb_mdu_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared decode constants and types for the MIPS multiply/divide unit.
package mdu_pkg;
  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MTHI = 6'b010001;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MTLO = 6'b010011;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV = 6'b011010;
  localparam logic [5:0] FN_DIVU = 6'b011011;
  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
  // encoding equals funct[1:0] of the four arithmetic instructions
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_e;
  function automatic logic is_fn(input logic [5:0] opc, input logic [5:0] fn, input logic [5:0] want);
    return opc == OPC_SPECIAL && fn == want;
  endfunction
  function automatic logic is_md(input logic [5:0] opc, input logic [5:0] fn);
    return opc == OPC_SPECIAL && fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                                            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational multiply/divide datapath returning {HI,LO}.
// Divider logic exists only when MDU_DIV_EN is defined.
import mdu_pkg::*;
module mdu_arith (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [1:0]  op_i,
  output logic [63:0] res_o,
  output logic        dz_o
);
  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'h0, a_i} * {32'h0, b_i};
`ifdef MDU_DIV_EN
  logic [31:0] den, qs, rs, qu, ru;
  logic ovf;
  assign dz_o = b_i == 32'h0;
  assign den = dz_o ? 32'd1 : b_i;
  // most-negative / -1 overflows; pin it to a defined result instead of trapping
  assign ovf = a_i == 32'h8000_0000 && den == 32'hFFFF_FFFF;
  assign qs = ovf ? 32'h8000_0000 : $signed(a_i) / $signed(den);
  assign rs = ovf ? 32'h0 : $signed(a_i) % $signed(den);
  assign qu = a_i / den;
  assign ru = a_i % den;
  always_comb
    res_o = op_i == OP_MULT  ? prod_s :
            op_i == OP_MULTU ? prod_u :
            op_i == OP_DIV   ? {rs, qs} : {ru, qu};
`else
  logic unused_op;
  assign unused_op = op_i[1];
  assign dz_o = 1'b0;
  assign res_o = op_i[0] ? prod_u : prod_s;
`endif
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MIPS MDU controller - busy counter, HI/LO registers and Decode stall request.
// Divide support is compiled in only when MDU_DIV_EN is defined.
import mdu_pkg::*;
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_Instr,
  input  logic        E_valid,
  input  logic [31:0] D_Instr,
  input  logic [31:0] RS_data,
  input  logic [31:0] RT_data,
  output logic        Busy,
  output logic        Stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_Result,
  output logic        Done
);
  localparam int CW = 16;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic [1:0] op_q, op_d;
  logic done_q, done_d;
  logic [63:0] res;
  logic dz, e_mul, e_div, start, fin;
  logic [5:0] e_opc, e_fn;
  logic unused_bits;
  assign unused_bits = ^{E_Instr[25:6], D_Instr[25:6]};
  assign e_opc = E_Instr[31:26];
  assign e_fn = E_Instr[5:0];
  assign e_mul = E_valid & (is_fn(e_opc, e_fn, FN_MULT) | is_fn(e_opc, e_fn, FN_MULTU));
`ifdef MDU_DIV_EN
  assign e_div = E_valid & (is_fn(e_opc, e_fn, FN_DIV) | is_fn(e_opc, e_fn, FN_DIVU));
`else
  assign e_div = 1'b0;
`endif
  assign start = (e_mul | e_div) & (state_q == ST_IDLE);
  assign fin = state_q == ST_BUSY && cnt_q == CW'(1);
  assign Busy = state_q == ST_BUSY;
  assign Stall_MD = is_md(D_Instr[31:26], D_Instr[5:0]) & (start | Busy);
  assign MD_Result = is_fn(e_opc, e_fn, FN_MFHI) ? hi_q :
                     is_fn(e_opc, e_fn, FN_MFLO) ? lo_q : 32'h0;
  assign HI = hi_q;
  assign LO = lo_q;
  assign Done = done_q;
  mdu_arith u_arith (.a_i(a_q), .b_i(b_q), .op_i(op_q), .res_o(res), .dz_o(dz));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    done_d = 1'b0;
    if (start) begin
      state_d = ST_BUSY;
      cnt_d = e_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      op_d = E_Instr[1:0];
      a_d = RS_data;
      b_d = RT_data;
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (fin) begin
        state_d = ST_IDLE;
        done_d = 1'b1;
        if (!dz) {hi_d, lo_d} = res;
      end
    end else if (E_valid) begin
      hi_d = is_fn(e_opc, e_fn, FN_MTHI) ? RS_data : hi_q;
      lo_d = is_fn(e_opc, e_fn, FN_MTLO) ? RS_data : lo_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vector bench for mdu_ctrl; div expectations follow MDU_DIV_EN.
module tb_mdu_ctrl;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1a, DIVU = 6'h1b;
  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13, ADDU = 6'h21;
`ifdef MDU_DIV_EN
  localparam int DC = 10;
`else
  localparam int DC = 0;
`endif
  typedef struct {
    logic [5:0]  fn;
    logic [31:0] rs, rt, hi, lo;
    int          cyc;
  } vec_t;
  logic clk = 1'b0, reset, E_valid, Busy, Stall_MD, Done;
  logic [31:0] E_Instr, D_Instr, RS_data, RT_data, HI, LO, MD_Result;
  int errors = 0, checks = 0;
  vec_t v[$];
  mdu_ctrl dut (.clk(clk), .reset(reset), .E_Instr(E_Instr), .E_valid(E_valid),
    .D_Instr(D_Instr), .RS_data(RS_data), .RT_data(RT_data), .Busy(Busy),
    .Stall_MD(Stall_MD), .HI(HI), .LO(LO), .MD_Result(MD_Result), .Done(Done));
  always #5 clk = ~clk;
  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h0, 5'd4, 5'd5, 10'h0, fn};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_op(input string nm, input logic [5:0] fn, input logic [31:0] a, b, hi, lo, input int cyc);
    int n = 0, dn = 0;
    @(negedge clk);
    E_Instr = rtype(fn); E_valid = 1'b1; RS_data = a; RT_data = b;
    @(negedge clk);
    E_valid = 1'b0; E_Instr = rtype(ADDU);
    while (Busy && n < 100) begin
      dn += int'(Done);
      n++;
      @(negedge clk);
    end
    chk({nm, " busy cycles"}, n, cyc);
    chk({nm, " early done"}, dn, 0);
    chk({nm, " done"}, Done, cyc != 0);
    chk({nm, " hi"}, HI, hi);
    chk({nm, " lo"}, LO, lo);
    @(negedge clk);
    chk({nm, " done clear"}, Done, 0);
  endtask
  task automatic mt(input logic [5:0] fn, input logic [31:0] d);
    @(negedge clk);
    E_Instr = rtype(fn); E_valid = 1'b1; RS_data = d;
    @(negedge clk);
    E_valid = 1'b0; E_Instr = rtype(ADDU);
  endtask
  initial begin
    int n;
    reset = 1'b0; E_valid = 1'b0; E_Instr = '0; D_Instr = rtype(ADDU); RS_data = '0; RT_data = '0;
    repeat (2) @(negedge clk);
    chk("reset hi", HI, 0);
    chk("reset lo", LO, 0);
    chk("reset busy", Busy, 0);
    chk("reset done", Done, 0);
    reset = 1'b1;
    v.push_back('{MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5});
    v.push_back('{MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5});
    v.push_back('{MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 5});
    v.push_back('{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 5});
    v.push_back('{MULT, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 5});
`ifdef MDU_DIV_EN
    v.push_back('{DIVU, 32'd7, 32'd2, 32'd1, 32'd3, DC});
    v.push_back('{DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC});
    v.push_back('{DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DC});
    v.push_back('{DIVU, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, DC});
`else
    v.push_back('{DIVU, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF9, DC});
    v.push_back('{DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF9, DC});
`endif
    foreach (v[i]) run_op($sformatf("vec%0d", i), v[i].fn, v[i].rs, v[i].rt, v[i].hi, v[i].lo, v[i].cyc);
    // reset in the middle of an operation discards it
    @(negedge clk);
    E_Instr = rtype(DC != 0 ? DIVU : MULT); E_valid = 1'b1; RS_data = 32'd7; RT_data = 32'd2;
    @(negedge clk);
    E_valid = 1'b0; E_Instr = rtype(ADDU);
    @(negedge clk);
    chk("midop busy", Busy, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst hi", HI, 0);
    chk("midrst lo", LO, 0);
    chk("midrst busy", Busy, 0);
    chk("midrst done", Done, 0);
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("postrst done", Done, 0);
    end
    run_op("after reset", MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);
    // divide by zero keeps HI/LO, still occupies the divider
    mt(MTHI, 32'h1234);
    mt(MTLO, 32'h5678);
    chk("mthi 1234", HI, 32'h1234);
    chk("mtlo 5678", LO, 32'h5678);
    run_op("div0", DIV, 32'd99, 32'd0, 32'h1234, 32'h5678, DC);
    // stall sequence: mult in E, mflo in D
    D_Instr = rtype(MFLO);
    @(negedge clk);
    #1 chk("stall idle", Stall_MD, 0);
    E_Instr = rtype(MULT); E_valid = 1'b1; RS_data = 32'h0001_0000; RT_data = 32'h0001_0003;
    #1 chk("stall start", Stall_MD, 1);
    @(negedge clk);
    E_Instr = rtype(MTLO); RS_data = 32'hDEAD;
    n = 0;
    while (Busy && n < 100) begin
      #1 chk("stall busy", Stall_MD, 1);
      if (n == 2) begin
        D_Instr = rtype(ADDU);
        #1 chk("stall addu", Stall_MD, 0);
        D_Instr = rtype(DIV);
        #1 chk("stall div", Stall_MD, 1);
        D_Instr = rtype(MFLO);
      end
      n++;
      @(negedge clk);
      E_valid = 1'b0;
    end
    #1 chk("stall cycles", n, 5);
    chk("stall released", Stall_MD, 0);
    chk("stall done", Done, 1);
    chk("stall hi", HI, 32'h1);
    chk("stall lo", LO, 32'h0003_0000);
    E_Instr = rtype(MFLO);
    #1 chk("mflo result", MD_Result, 32'h0003_0000);
    E_Instr = rtype(MFHI);
    #1 chk("mfhi result", MD_Result, 32'h1);
    E_Instr = rtype(ADDU);
    #1 chk("addu result", MD_Result, 0);
    D_Instr = rtype(ADDU);
    mt(MTHI, 32'hA5A5_A5A5);
    chk("mthi a5", HI, 32'hA5A5_A5A5);
    chk("mthi lo kept", LO, 32'h0003_0000);
    chk("mthi busy", Busy, 0);
    chk("mthi done", Done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
